// File: rtl/clkarb_pkg.sv
// Shared constants, FSM state type and clamp helper for the clock rate arbiter.
// The arbitration scheme is selected by CLKARB_FIXED_PRI_EN (see clkarb_rr_arbiter).
package clkarb_pkg;
    localparam int NREQ = 4;
    localparam int N_W  = 32;
    localparam int ID_W = 2;

    localparam int unsigned DFLT_N     = 10;
    localparam int unsigned DFLT_MIN_N = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] n, input logic [N_W-1:0] lo);
        return (n < lo) ? lo : n;
    endfunction
endpackage

// File: rtl/clkarb_rr_arbiter.sv
// 4-way arbiter with one-hot grant; round-robin by default, fixed priority
// (req[0] highest) when CLKARB_FIXED_PRI_EN is defined.
module clkarb_rr_arbiter
    import clkarb_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                gnt_id = idx;
                any    = 1'b1;
            end
        end
        if (any) gnt[gnt_id] = 1'b1;
    end

    // Fixed priority is round-robin with the search start pinned at 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (accept) begin
`ifdef CLKARB_FIXED_PRI_EN
            ptr <= '0;
`else
            ptr <= gnt_id + ID_W'(1);
`endif
        end
    end
endmodule

// File: rtl/clock_rate_arbiter.sv
// Clock divider whose ratio is renegotiated by four requesters; a captured ratio
// takes effect only on an outclk 1->0 boundary. Arbitration mode: CLKARB_FIXED_PRI_EN.
module clock_rate_arbiter
    import clkarb_pkg::*;
#(
    parameter int unsigned DEFAULT_N = DFLT_N,
    parameter int unsigned MIN_N     = DFLT_MIN_N
) (
    input  logic                 refclk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*N_W-1:0]  req_n,
    output logic [NREQ-1:0]      grant,
    output logic                 switched,
    output logic                 pending,
    output logic [N_W-1:0]       active_n,
    output logic [ID_W-1:0]      active_id,
    output logic                 outclk
);
    state_t                     state;
    logic [N_W-1:0]             counter;
    logic [N_W-1:0]             half;
    logic [N_W-1:0]             pend_n;
    logic [ID_W-1:0]            pend_id;
    logic                       toggle;
    logic                       boundary;
    logic                       accept;
    logic [NREQ-1:0]            sel;
    logic [ID_W-1:0]            sel_id;
    logic                       sel_any;
    logic [NREQ-1:0][N_W-1:0]   lanes;

    assign lanes    = req_n;
    assign half     = (active_n >> 1) - N_W'(1);
    assign toggle   = (counter >= half);
    assign boundary = toggle && outclk;
    assign accept   = (state == IDLE) && sel_any;
    assign pending  = (state == WAIT);

    clkarb_rr_arbiter u_arb (
        .clk    (refclk),
        .resetn (resetn),
        .req    (req),
        .accept (accept),
        .gnt    (sel),
        .gnt_id (sel_id),
        .any    (sel_any)
    );

    always_ff @(posedge refclk) begin
        if (!resetn) begin
            state     <= IDLE;
            counter   <= '0;
            outclk    <= 1'b0;
            active_n  <= N_W'(DEFAULT_N);
            active_id <= '0;
            pend_n    <= '0;
            pend_id   <= '0;
            grant     <= '0;
            switched  <= 1'b0;
        end else begin
            grant    <= '0;
            switched <= 1'b0;
            if (toggle) begin
                outclk  <= ~outclk;
                counter <= '0;
            end else begin
                counter <= counter + N_W'(1);
            end
            // WAIT ignores req, so an apply and a capture never share a cycle.
            case (state)
                IDLE: if (sel_any) begin
                    pend_n  <= clamp_n(lanes[sel_id], N_W'(MIN_N));
                    pend_id <= sel_id;
                    grant   <= sel;
                    state   <= WAIT;
                end
                WAIT: if (boundary) begin
                    active_n  <= pend_n;
                    active_id <= pend_id;
                    counter   <= '0;
                    outclk    <= 1'b0;
                    switched  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_rate_arbiter.sv
// Directed bench for clock_rate_arbiter: a per-cycle vector table plus hand-written
// sequences for clamping, arbitration order, same-ratio requests and reset in WAIT.
module tb_clock_rate_arbiter;
    logic         refclk = 1'b0;
    logic         resetn = 1'b0;
    logic [3:0]   req    = '0;
    logic [127:0] req_n  = '0;
    logic [3:0]   grant;
    logic         switched;
    logic         pending;
    logic [31:0]  active_n;
    logic [1:0]   active_id;
    logic         outclk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] n;
        logic        ock;
        logic [3:0]  gnt;
        logic        sw;
        logic        pend;
        logic [31:0] an;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[$];
    int   order[$];
    int   exp_order[5];
    int   sw_between;
    int   stray;

    clock_rate_arbiter #(.DEFAULT_N(10), .MIN_N(2)) dut (
        .refclk    (refclk),
        .resetn    (resetn),
        .req       (req),
        .req_n     (req_n),
        .grant     (grant),
        .switched  (switched),
        .pending   (pending),
        .active_n  (active_n),
        .active_id (active_id),
        .outclk    (outclk)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Leaves the bench at "k=0": the sample right after the last reset edge.
    task automatic do_reset();
        req    = '0;
        req_n  = '0;
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
    endtask

    task automatic set_lane(input int lane, input logic [31:0] v);
        req_n[32*lane +: 32] = v;
    endtask

    function automatic int onehot_idx(input logic [3:0] g);
        int r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        // Reset state and free-running default ratio 10
        do_reset();
        check("rst.outclk", outclk, 0);
        check("rst.active_n", active_n, 10);
        check("rst.active_id", active_id, 0);
        check("rst.pending", pending, 0);
        check("rst.grant", grant, 0);
        check("rst.switched", switched, 0);
        stray = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            check($sformatf("idle.outclk.k%0d", k), outclk, (k / 5) & 1);
            if (grant != 0 || switched) stray++;
        end
        check("idle.stray_pulses", stray, 0);
        check("idle.active_n", active_n, 10);

        // Request 4 on lane 2 mid-high-phase; req[0] raised during WAIT is ignored
        for (int k = 1; k <= 6; k++)
            tbl.push_back('{4'b0000, 32'd0, ((k / 5) & 1) != 0, 4'b0000, 1'b0, 1'b0, 32'd10, 2'd0});
        tbl.push_back('{4'b0100, 32'd4, 1'b1, 4'b0100, 1'b0, 1'b1, 32'd10, 2'd0});
        tbl.push_back('{4'b0101, 32'd4, 1'b1, 4'b0000, 1'b0, 1'b1, 32'd10, 2'd0});
        tbl.push_back('{4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 32'd10, 2'd0});
        tbl.push_back('{4'b0000, 32'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        tbl.push_back('{4'b0000, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd4,  2'd2});
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req   = tbl[i].req;
            req_n = {4{tbl[i].n}};
            step();
            check($sformatf("vec%0d.outclk", i + 1), outclk, tbl[i].ock);
            check($sformatf("vec%0d.grant", i + 1), grant, tbl[i].gnt);
            check($sformatf("vec%0d.switched", i + 1), switched, tbl[i].sw);
            check($sformatf("vec%0d.pending", i + 1), pending, tbl[i].pend);
            check($sformatf("vec%0d.active_n", i + 1), active_n, tbl[i].an);
            check($sformatf("vec%0d.active_id", i + 1), active_id, tbl[i].id);
        end

        // Ratio 1 clamps to 2, then ratio 0 also clamps to 2
        do_reset();
        req = 4'b0010;
        set_lane(1, 32'd1);
        step();
        check("clamp1.grant", grant, 4'b0010);
        req = '0;
        step(9);
        check("clamp1.switched", switched, 1);
        check("clamp1.active_n", active_n, 2);
        check("clamp1.active_id", active_id, 1);
        for (int j = 1; j <= 4; j++) begin
            step();
            check($sformatf("clamp1.outclk.%0d", j), outclk, j & 1);
        end
        req = 4'b1000;
        set_lane(3, 32'd0);
        step();
        check("clamp0.grant", grant, 4'b1000);
        req = '0;
        step();
        check("clamp0.switched", switched, 1);
        check("clamp0.active_n", active_n, 2);
        check("clamp0.active_id", active_id, 3);

        // Same ratio as active still grants and switches; then ratio 7 gives period 6
        do_reset();
        req = 4'b0001;
        set_lane(0, 32'd10);
        step();
        check("same.grant", grant, 4'b0001);
        req = '0;
        step(9);
        check("same.switched", switched, 1);
        check("same.active_n", active_n, 10);
        req = 4'b0001;
        set_lane(0, 32'd7);
        step();
        check("odd.grant", grant, 4'b0001);
        req = '0;
        step(9);
        check("odd.switched", switched, 1);
        check("odd.active_n", active_n, 7);
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("odd.outclk.%0d", j), outclk, (j / 3) & 1);
        end

        // All four requesting continuously: grant order
`ifdef CLKARB_FIXED_PRI_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        req_n = {4{32'd2}};
        req   = 4'hF;
        sw_between = 0;
        order.delete();
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            step();
            if (switched) sw_between++;
            if (grant != 0) begin
                check("arb.onehot", $onehot(grant), 1);
                if (order.size() > 0) check("arb.applies_between", sw_between, 1);
                sw_between = 0;
                order.push_back(onehot_idx(grant));
            end
        end
        req = '0;
        check("arb.grant_count", order.size(), 5);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("arb.order%0d", i), order[i], exp_order[i]);

        // Reset while a ratio is pending during the high phase
        do_reset();
        step(5);
        req = 4'b0100;
        set_lane(2, 32'd4);
        step();
        check("rstwait.grant", grant, 4'b0100);
        check("rstwait.pending_before", pending, 1);
        check("rstwait.outclk_before", outclk, 1);
        req    = '0;
        resetn = 1'b0;
        step();
        check("rstwait.active_n", active_n, 10);
        check("rstwait.pending", pending, 0);
        check("rstwait.outclk", outclk, 0);
        check("rstwait.switched", switched, 0);
        check("rstwait.grant_after", grant, 0);
        resetn = 1'b1;
        stray = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (switched || grant != 0) stray++;
        end
        check("rstwait.no_late_pulse", stray, 0);
        check("rstwait.active_n_late", active_n, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
